// File: rtl/addsub_rr_arbiter_if.sv
// Bundle of requester, adder and response signals shared by the round-robin adder arbiter.
// The slave modport is the arbiter's view; the master modport is the clients plus adder.
interface addsub_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [2*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;

  logic [31:0]           as_a;
  logic [31:0]           as_b;
  logic                  as_ctl0;
  logic                  as_ctl1;
  logic [31:0]           as_out;
  logic                  as_zero;
  logic                  as_ovf;
  logic                  as_cout;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic                  rsp_zero;
  logic                  rsp_ovf;
  logic                  rsp_cout;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready,
    output as_a, as_b, as_ctl0, as_ctl1,
    input  as_out, as_zero, as_ovf, as_cout,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_ovf, rsp_cout,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready,
    input  as_a, as_b, as_ctl0, as_ctl1,
    output as_out, as_zero, as_ovf, as_cout,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_ovf, rsp_cout,
    output rsp_ready
  );
endinterface

// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ADD/SUB/SLT adder among NUM_REQ clients,
// with a single registered response slot and a running grant counter.
module addsub_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addsub_rr_arbiter_if.slave   bus,
  output logic [15:0]          grant_cnt
);
  localparam int WIDTH = 32;
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic [15:0]      grant_cnt_q, grant_cnt_d;

  logic             found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  cand;
  logic             slot_open;
  logic             fire;
  logic [1:0]       op_mux;

  // Scan starts one past the last winner so every client gets a turn.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  assign slot_open = !rsp_valid_q || bus.rsp_ready;
  assign fire      = found && slot_open && rst_n;

  always_comb begin
    bus.as_a = '0;
    bus.as_b = '0;
    op_mux   = 2'b00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && win_id == ID_W'(i)) begin
        bus.as_a = bus.req_a[i*WIDTH +: WIDTH];
        bus.as_b = bus.req_b[i*WIDTH +: WIDTH];
        op_mux   = bus.req_op[2*i +: 2];
      end
    end
  end

  assign bus.as_ctl0  = op_mux[1] | op_mux[0];
  assign bus.as_ctl1  = op_mux[1];
  assign bus.req_ready = fire ? (NUM_REQ'(1) << win_id) : '0;

  // A new grant overwrites the slot even when the old response is consumed the same cycle.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_cout_d  = rsp_cout_q;
    grant_cnt_d = grant_cnt_q;
    if (fire) begin
      ptr_d       = win_id;
      rsp_valid_d = 1'b1;
      rsp_id_d    = win_id;
      rsp_data_d  = bus.as_out;
      rsp_zero_d  = bus.as_zero;
      rsp_ovf_d   = bus.as_ovf;
      rsp_cout_d  = bus.as_cout;
      grant_cnt_d = grant_cnt_q + 16'd1;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= ID_W'(NUM_REQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_cout_q  <= 1'b0;
      grant_cnt_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_cout_q  <= rsp_cout_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign grant_cnt     = grant_cnt_q;
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Directed bench for addsub_rr_arbiter with a behavioural 32-bit AdderSubtractor attached.
module tb_addsub_rr_arbiter;
  localparam int NUM_REQ = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] grant_cnt;

  int n_chk;
  int n_pass;

  addsub_rr_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  addsub_rr_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .grant_cnt (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference AdderSubtractor: SLT reports the signed less-than (sign xor overflow).
  logic [31:0] bop;
  logic [32:0] sum;
  logic        add_ovf;
  logic [31:0] add_res;
  always_comb begin
    bop         = bus.as_ctl0 ? ~bus.as_b : bus.as_b;
    sum         = {1'b0, bus.as_a} + {1'b0, bop} + {32'd0, bus.as_ctl0};
    add_ovf     = (bus.as_a[31] == bop[31]) && (sum[31] != bus.as_a[31]);
    add_res     = bus.as_ctl1 ? {31'd0, sum[31] ^ add_ovf} : sum[31:0];
    bus.as_out  = add_res;
    bus.as_zero = (add_res == 32'd0);
    bus.as_ovf  = add_ovf;
    bus.as_cout = sum[32];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i]       = v;
    bus.req_op[2*i +: 2]   = op;
    bus.req_a[32*i +: 32]  = a;
    bus.req_b[32*i +: 32]  = b;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    clear_reqs();
    #2;
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_grant_cnt", {16'd0, grant_cnt}, 32'd0);
    check("rst_as_a_idle", bus.as_a, 32'd0);
    #10;
    rst_n = 1'b1;

    // Single ADD from requester 0
    tick();
    bus.rsp_ready = 1'b1;
    drive(0, 1'b1, 2'b00, 32'd5, 32'd7);
    #1;
    check("t1_req_ready", {28'd0, bus.req_ready}, 32'h1);
    check("t1_as_a", bus.as_a, 32'd5);
    check("t1_as_ctl0", {31'd0, bus.as_ctl0}, 32'd0);
    tick();
    check("t1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("t1_rsp_id", {30'd0, bus.rsp_id}, 32'd0);
    check("t1_rsp_data", bus.rsp_data, 32'd12);
    check("t1_rsp_zero", {31'd0, bus.rsp_zero}, 32'd0);
    check("t1_grant_cnt", {16'd0, grant_cnt}, 32'd1);
    clear_reqs();
    tick();
    check("t1_drain_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("t1_drain_hold", bus.rsp_data, 32'd12);

    // All four valid: pointer sits at 0, so order is 1,2,3,0,1
    for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b1, 2'b00, 32'd100 + 32'(i), 32'(i));
    for (int k = 0; k < 5; k++) begin
      int e;
      e = (1 + k) % NUM_REQ;
      #1;
      check("t2_req_ready", {28'd0, bus.req_ready}, 32'h1 << e);
      tick();
      check("t2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("t2_rsp_id", {30'd0, bus.rsp_id}, 32'(e));
      check("t2_rsp_data", bus.rsp_data, 32'd100 + 32'(2 * e));
      check("t2_grant_cnt", {16'd0, grant_cnt}, 32'(2 + k));
    end
    clear_reqs();
    tick();

    // SUB 3-3 from requester 1, then stall the consumer for three cycles
    drive(1, 1'b1, 2'b01, 32'd3, 32'd3);
    #1;
    check("t3_req_ready", {28'd0, bus.req_ready}, 32'h2);
    tick();
    check("t3_rsp_id", {30'd0, bus.rsp_id}, 32'd1);
    clear_reqs();
    drive(2, 1'b1, 2'b00, 32'd20, 32'd22);
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_stall_ready", {28'd0, bus.req_ready}, 32'd0);
      tick();
      check("t3_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("t3_hold_data", bus.rsp_data, 32'd0);
      check("t3_hold_zero", {31'd0, bus.rsp_zero}, 32'd1);
      check("t3_hold_cout", {31'd0, bus.rsp_cout}, 32'd1);
      check("t3_hold_id", {30'd0, bus.rsp_id}, 32'd1);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("t3_resume_ready", {28'd0, bus.req_ready}, 32'h4);
    tick();
    check("t3_resume_id", {30'd0, bus.rsp_id}, 32'd2);
    check("t3_resume_data", bus.rsp_data, 32'd42);
    check("t3_grant_cnt", {16'd0, grant_cnt}, 32'd8);
    clear_reqs();

    // SLT via op 10, then a signed-overflowing SUB, both from requester 3
    drive(3, 1'b1, 2'b10, 32'h8000_0000, 32'h1);
    #1;
    check("t4_ctl0", {31'd0, bus.as_ctl0}, 32'd1);
    check("t4_ctl1", {31'd0, bus.as_ctl1}, 32'd1);
    tick();
    check("t4_slt_id", {30'd0, bus.rsp_id}, 32'd3);
    check("t4_slt_data", bus.rsp_data, 32'd1);
    check("t4_slt_ovf", {31'd0, bus.rsp_ovf}, 32'd1);
    check("t4_slt_cout", {31'd0, bus.rsp_cout}, 32'd1);
    drive(3, 1'b1, 2'b01, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    tick();
    check("t4_sub_data", bus.rsp_data, 32'h8000_0000);
    check("t4_sub_ovf", {31'd0, bus.rsp_ovf}, 32'd1);
    check("t4_sub_cout", {31'd0, bus.rsp_cout}, 32'd0);
    check("t4_grant_cnt", {16'd0, grant_cnt}, 32'd10);
    clear_reqs();
    bus.rsp_ready = 1'b0;

    // Asynchronous reset with a response pending
    #3;
    check("t5_pre_valid", {31'd0, bus.rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("t5_rst_data", bus.rsp_data, 32'd0);
    check("t5_rst_ovf", {31'd0, bus.rsp_ovf}, 32'd0);
    check("t5_rst_cnt", {16'd0, grant_cnt}, 32'd0);
    for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b1, 2'b00, 32'd100 + 32'(i), 32'(i));
    bus.rsp_ready = 1'b1;
    #1;
    check("t5_rst_no_ready", {28'd0, bus.req_ready}, 32'd0);
    tick();
    check("t5_rst_hold", {31'd0, bus.rsp_valid}, 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check("t5_first_ready", {28'd0, bus.req_ready}, 32'h1);
    tick();
    check("t5_first_id", {30'd0, bus.rsp_id}, 32'd0);
    check("t5_first_data", bus.rsp_data, 32'd100);
    check("t5_first_cnt", {16'd0, grant_cnt}, 32'd1);

    // Grant counter wrap
    clear_reqs();
    drive(0, 1'b1, 2'b00, 32'd1, 32'd1);
    for (int k = 0; k < 65534; k++) tick();
    check("t6_cnt_max", {16'd0, grant_cnt}, 32'h0000_FFFF);
    tick();
    check("t6_cnt_wrap", {16'd0, grant_cnt}, 32'd0);
    check("t6_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("t6_rsp_data", bus.rsp_data, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
